// File: rtl/decode_ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_ctrl_pipe_if
//  Description : Bundle of the ID-side handshake and the ID/EX control word
//                for decode_ctrl_pipe.
//                master : drives the ID instruction fields and flush and
//                         observes the handshake and EX control outputs.
//                slave  : the control unit itself.
//  Signals     : id_valid, id_opcode[OPW], id_rs/id_rt/id_rd[REGW], flush
//                (master -> slave)
//                id_ready, stall, mul_busy, ex_valid, ex_wen, ex_alusrc,
//                ex_regdst, ex_memwrite, ex_memtoreg, ex_memread, ex_branch,
//                ex_jump, ex_jr, ex_jal, ex_aluop[3], ex_wreg[REGW],
//                ex_illegal (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_ctrl_pipe_if #(
  parameter int OPW  = 4,
  parameter int REGW = 4
);
  // ID side
  logic            id_valid;
  logic [OPW-1:0]  id_opcode;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic [REGW-1:0] id_rd;
  logic            flush;
  logic            id_ready;
  logic            stall;
  logic            mul_busy;

  // EX side
  logic            ex_valid;
  logic            ex_wen;
  logic            ex_alusrc;
  logic            ex_regdst;
  logic            ex_memwrite;
  logic            ex_memtoreg;
  logic            ex_memread;
  logic            ex_branch;
  logic            ex_jump;
  logic            ex_jr;
  logic            ex_jal;
  logic [2:0]      ex_aluop;
  logic [REGW-1:0] ex_wreg;
  logic            ex_illegal;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
    input  id_ready, stall, mul_busy,
    input  ex_valid, ex_wen, ex_alusrc, ex_regdst, ex_memwrite, ex_memtoreg,
    input  ex_memread, ex_branch, ex_jump, ex_jr, ex_jal, ex_aluop, ex_wreg,
    input  ex_illegal
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
    output id_ready, stall, mul_busy,
    output ex_valid, ex_wen, ex_alusrc, ex_regdst, ex_memwrite, ex_memtoreg,
    output ex_memread, ex_branch, ex_jump, ex_jr, ex_jal, ex_aluop, ex_wreg,
    output ex_illegal
  );
endinterface
`default_nettype wire

// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : decode_ctrl_pipe
//  Description : Pipelined control unit. Decodes the ID-stage opcode into a
//                control word and registers it into the ID/EX register.
//                Inserts a single bubble on a load-use hazard, holds EX for
//                MUL_CYCLES cycles on a MUL, and kills ID/EX on flush.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - decode_ctrl_pipe_if.slave (ID handshake, flush,
//                         stall/mul_busy status and the registered EX word)
//  Opcodes     : ADD=0 SUB=1 AND=2 XOR=3 COM=4 MUL=5 SLL=6 SRL=7 ADDI=8
//                LW=9 SW=10 BEQ=11 J=12 JR=13 JAL=14; 15 is undefined.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_ctrl_pipe #(
  parameter int OPW        = 4,
  parameter int REGW       = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_ctrl_pipe_if.slave bus
);

  localparam int              CNTW     = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNTW-1:0] MUL_LOAD = CNTW'(MUL_CYCLES - 1);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(3);
  localparam logic [OPW-1:0] OP_COM  = OPW'(4);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(7);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(8);
  localparam logic [OPW-1:0] OP_LW   = OPW'(9);
  localparam logic [OPW-1:0] OP_SW   = OPW'(10);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(11);
  localparam logic [OPW-1:0] OP_J    = OPW'(12);
  localparam logic [OPW-1:0] OP_JR   = OPW'(13);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(14);

  typedef struct packed {
    logic            valid;
    logic            wen;
    logic            alusrc;
    logic            regdst;
    logic            memwrite;
    logic            memtoreg;
    logic            memread;
    logic            branch;
    logic            jump;
    logic            jr;
    logic            jal;
    logic [2:0]      aluop;
    logic [REGW-1:0] wreg;
    logic            illegal;
  } ex_word_t;

  ex_word_t        dec_word;
  ex_word_t        ex_reg;
  logic [CNTW-1:0] mul_cnt;
  logic            mul_busy;
  logic            rs_used;
  logic            rt_used;
  logic            load_use;
  logic            mul_start;

  // --------------------------------------------------------------------------
  // Decode table. An undefined opcode still produces a valid EX entry, but
  // with only the illegal flag set so the later stages can trap on it.
  // --------------------------------------------------------------------------
  always_comb begin
    dec_word       = '0;
    dec_word.valid = 1'b1;
    case (bus.id_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL: begin
        dec_word.wen   = 1'b1;
        dec_word.aluop = bus.id_opcode[2:0];
      end
      OP_SLL, OP_SRL: begin
        dec_word.wen    = 1'b1;
        dec_word.alusrc = 1'b1;
        dec_word.aluop  = bus.id_opcode[2:0];
      end
      OP_ADDI: begin
        dec_word.wen    = 1'b1;
        dec_word.alusrc = 1'b1;
      end
      OP_LW: begin
        dec_word.wen      = 1'b1;
        dec_word.alusrc   = 1'b1;
        dec_word.memtoreg = 1'b1;
        dec_word.memread  = 1'b1;
      end
      OP_SW: begin
        dec_word.alusrc   = 1'b1;
        dec_word.regdst   = 1'b1;
        dec_word.memwrite = 1'b1;
      end
      OP_BEQ: begin
        dec_word.branch = 1'b1;
        dec_word.regdst = 1'b1;
        dec_word.aluop  = bus.id_opcode[2:0];
      end
      OP_J: begin
        dec_word.jump  = 1'b1;
        dec_word.aluop = bus.id_opcode[2:0];
      end
      OP_JR: begin
        dec_word.jr    = 1'b1;
        dec_word.aluop = bus.id_opcode[2:0];
      end
      OP_JAL: begin
        dec_word.jal   = 1'b1;
        dec_word.aluop = bus.id_opcode[2:0];
      end
      default: begin
        dec_word.illegal = 1'b1;
      end
    endcase
    // r0 is hardwired to zero, so a write to it is suppressed entirely and
    // can never be the source of a load-use hazard.
    if (bus.id_rd == '0) begin
      dec_word.wen = 1'b0;
    end
    dec_word.wreg = dec_word.wen ? bus.id_rd : '0;
  end

  // --------------------------------------------------------------------------
  // Source-operand usage, for the hazard check only.
  // --------------------------------------------------------------------------
  always_comb begin
    rs_used = !((bus.id_opcode == OP_J) || (bus.id_opcode == OP_JAL));
    rt_used = (bus.id_opcode inside {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM,
                                      OP_MUL, OP_SW, OP_BEQ});
  end

  assign mul_busy = (mul_cnt != '0);

  assign load_use = ex_reg.valid && ex_reg.memread && (ex_reg.wreg != '0) &&
                    bus.id_valid &&
                    ((rs_used && (bus.id_rs == ex_reg.wreg)) ||
                     (rt_used && (bus.id_rt == ex_reg.wreg)));

  // A single-cycle MUL needs no hold, so the counter is never armed.
  if (MUL_CYCLES > 1) begin : g_mul_hold
    assign mul_start = (bus.id_opcode == OP_MUL);
  end else begin : g_no_mul_hold
    assign mul_start = 1'b0;
  end

  // Handshake, in priority order: flush, MUL hold, load-use, accept.
  assign bus.stall    = !bus.flush && !mul_busy && load_use;
  assign bus.id_ready = bus.flush || (!mul_busy && !load_use);

  // --------------------------------------------------------------------------
  // ID/EX register and MUL hold counter.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg  <= '0;
      mul_cnt <= '0;
    end else if (bus.flush) begin
      ex_reg  <= '0;
      mul_cnt <= '0;
    end else if (mul_busy) begin
      // EX contents stay put while the multiplier is still working.
      mul_cnt <= mul_cnt - CNTW'(1);
    end else if (load_use) begin
      ex_reg <= '0;
    end else if (bus.id_valid) begin
      ex_reg  <= dec_word;
      mul_cnt <= mul_start ? MUL_LOAD : '0;
    end else begin
      ex_reg <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.mul_busy    = mul_busy;
  assign bus.ex_valid    = ex_reg.valid;
  assign bus.ex_wen      = ex_reg.wen;
  assign bus.ex_alusrc   = ex_reg.alusrc;
  assign bus.ex_regdst   = ex_reg.regdst;
  assign bus.ex_memwrite = ex_reg.memwrite;
  assign bus.ex_memtoreg = ex_reg.memtoreg;
  assign bus.ex_memread  = ex_reg.memread;
  assign bus.ex_branch   = ex_reg.branch;
  assign bus.ex_jump     = ex_reg.jump;
  assign bus.ex_jr       = ex_reg.jr;
  assign bus.ex_jal      = ex_reg.jal;
  assign bus.ex_aluop    = ex_reg.aluop;
  assign bus.ex_wreg     = ex_reg.wreg;
  assign bus.ex_illegal  = ex_reg.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_ctrl_pipe
//  Description : Self-checking bench for decode_ctrl_pipe. Two lanes run in
//                parallel: lane 0 with MUL_CYCLES=3 and lane 1 with
//                MUL_CYCLES=1. A behavioural model predicts each cycle's
//                outputs into a per-lane queue; a monitor per lane pops and
//                compares on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_ctrl_pipe;

  localparam int OPW  = 4;
  localparam int REGW = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_COM  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_LW   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_J    = 4'd12;
  localparam logic [3:0] OP_JR   = 4'd13;
  localparam logic [3:0] OP_JAL  = 4'd14;
  localparam logic [3:0] OP_BAD  = 4'd15;

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic       alusrc;
    logic       regdst;
    logic       memwrite;
    logic       memtoreg;
    logic       memread;
    logic       branch;
    logic       jump;
    logic       jr;
    logic       jal;
    logic [2:0] aluop;
    logic [3:0] wreg;
    logic       illegal;
  } ex_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] rd;
    logic       flush;
  } stim_t;

  typedef struct packed {
    logic id_ready;
    logic stall;
    logic mul_busy;
    ex_t  ex;
  } exp_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  bit    rst_req = 1'b1;
  stim_t cur[2] = '{default: '0};
  bit    rdy[2];
  int    mul_cyc[2] = '{3, 1};
  ex_t   m_ex[2] = '{default: '0};
  int    m_mul[2] = '{0, 0};
  exp_t  q[2][$];
  string tq[2][$];
  string phase = "reset";
  int    vectors = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Lanes: interface, DUT and monitor
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_lane
    decode_ctrl_pipe_if #(.OPW(OPW), .REGW(REGW)) bus ();

    decode_ctrl_pipe #(
      .OPW(OPW), .REGW(REGW), .MUL_CYCLES(g == 0 ? 3 : 1)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    assign bus.id_valid  = cur[g].valid;
    assign bus.id_opcode = cur[g].op;
    assign bus.id_rs     = cur[g].rs;
    assign bus.id_rt     = cur[g].rt;
    assign bus.id_rd     = cur[g].rd;
    assign bus.flush     = cur[g].flush;

    exp_t act;
    always_comb begin
      act             = '0;
      act.id_ready    = bus.id_ready;
      act.stall       = bus.stall;
      act.mul_busy    = bus.mul_busy;
      act.ex.valid    = bus.ex_valid;
      act.ex.wen      = bus.ex_wen;
      act.ex.alusrc   = bus.ex_alusrc;
      act.ex.regdst   = bus.ex_regdst;
      act.ex.memwrite = bus.ex_memwrite;
      act.ex.memtoreg = bus.ex_memtoreg;
      act.ex.memread  = bus.ex_memread;
      act.ex.branch   = bus.ex_branch;
      act.ex.jump     = bus.ex_jump;
      act.ex.jr       = bus.ex_jr;
      act.ex.jal      = bus.ex_jal;
      act.ex.aluop    = bus.ex_aluop;
      act.ex.wreg     = bus.ex_wreg;
      act.ex.illegal  = bus.ex_illegal;
    end

    always @(negedge clk) begin
      exp_t  e;
      string t;
      if (q[g].size() > 0) begin
        e = q[g].pop_front();
        t = tq[g].pop_front();
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL lane%0d %s @%0t: ready/stall/busy got %b/%b/%b want %b/%b/%b, ex word got %h want %h",
                   g, t, $time, act.id_ready, act.stall, act.mul_busy,
                   e.id_ready, e.stall, e.mul_busy, act.ex, e.ex);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic ex_t ref_decode(stim_t s);
    ex_t e;
    e       = '0;
    e.valid = 1'b1;
    if (s.op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL}) begin
      e.wen = 1'b1; e.aluop = s.op[2:0];
    end else if (s.op inside {OP_SLL, OP_SRL}) begin
      e.wen = 1'b1; e.alusrc = 1'b1; e.aluop = s.op[2:0];
    end else begin
      case (s.op)
        OP_ADDI: begin e.wen = 1'b1; e.alusrc = 1'b1; end
        OP_LW:   begin e.wen = 1'b1; e.alusrc = 1'b1; e.memtoreg = 1'b1; e.memread = 1'b1; end
        OP_SW:   begin e.alusrc = 1'b1; e.regdst = 1'b1; e.memwrite = 1'b1; end
        OP_BEQ:  begin e.branch = 1'b1; e.regdst = 1'b1; e.aluop = s.op[2:0]; end
        OP_J:    begin e.jump = 1'b1; e.aluop = s.op[2:0]; end
        OP_JR:   begin e.jr = 1'b1; e.aluop = s.op[2:0]; end
        OP_JAL:  begin e.jal = 1'b1; e.aluop = s.op[2:0]; end
        default: e.illegal = 1'b1;
      endcase
    end
    if (s.rd == 4'd0) e.wen = 1'b0;
    e.wreg = e.wen ? s.rd : 4'd0;
    return e;
  endfunction

  function automatic bit reads_rs(logic [3:0] op);
    return !(op == OP_J || op == OP_JAL);
  endfunction

  function automatic bit reads_rt(logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL, OP_SW, OP_BEQ};
  endfunction

  // Predict this cycle's outputs for lane k and advance the lane's state.
  task automatic model_step(input int k);
    exp_t  x;
    stim_t s;
    bit    hazard;
    bit    busy;
    s = cur[k];
    if (rst_req) begin
      m_ex[k]  = '0;
      m_mul[k] = 0;
    end
    busy       = (m_mul[k] > 0);
    x          = '0;
    x.ex       = m_ex[k];
    x.mul_busy = busy;
    hazard = m_ex[k].valid && m_ex[k].memread && (m_ex[k].wreg != 4'd0) && s.valid &&
             ((reads_rs(s.op) && s.rs == m_ex[k].wreg) ||
              (reads_rt(s.op) && s.rt == m_ex[k].wreg));
    if (rst_req) begin
      x.id_ready = 1'b1;
    end else if (s.flush) begin
      x.id_ready = 1'b1;
      m_ex[k]    = '0;
      m_mul[k]   = 0;
    end else if (busy) begin
      m_mul[k] = m_mul[k] - 1;
    end else if (hazard) begin
      x.stall = 1'b1;
      m_ex[k] = '0;
    end else if (s.valid) begin
      x.id_ready = 1'b1;
      m_ex[k]    = ref_decode(s);
      m_mul[k]   = (s.op == OP_MUL) ? mul_cyc[k] - 1 : 0;
    end else begin
      x.id_ready = 1'b1;
      m_ex[k]    = '0;
    end
    rdy[k] = x.id_ready;
    q[k].push_back(x);
    tq[k].push_back(phase);
  endtask

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic apply();
    rst_n = !rst_req;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cur[0] = '0;
      cur[1] = '0;
      apply();
    end
  endtask

  function automatic stim_t mk(logic [3:0] op, logic [3:0] rs, logic [3:0] rt,
                               logic [3:0] rd, logic fl);
    stim_t s;
    s.valid = 1'b1; s.op = op; s.rs = rs; s.rt = rt; s.rd = rd; s.flush = fl;
    return s;
  endfunction

  // Hold an instruction in ID of lane k until it is consumed.
  task automatic send(input int k, input stim_t s);
    int n;
    n = 0;
    do begin
      cur[k]     = s;
      cur[1 - k] = '0;
      apply();
      n++;
    end while (!rdy[k] && n < 20);
    if (!rdy[k]) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: lane%0d instruction not consumed within 20 cycles", phase, k);
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.valid = ($urandom_range(9) != 0);
    s.op    = ($urandom_range(3) == 0) ? OP_LW : 4'($urandom_range(15));
    s.rs    = 4'($urandom_range(3));
    s.rt    = 4'($urandom_range(3));
    s.rd    = 4'($urandom_range(3));
    s.flush = 1'b0;
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    stim_t pend[2];
    bit    have[2];
    have = '{0, 0};

    @(posedge clk);
    #2;
    phase = "reset";
    rst_req = 1'b1;
    idle(2);
    rst_req = 1'b0;
    idle(1);

    phase = "add_rd3";
    send(0, mk(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0));
    phase = "addi_rd0";
    send(0, mk(OP_ADDI, 4'd1, 4'd0, 4'd0, 1'b0));
    idle(1);

    phase = "load_use_rs";
    send(0, mk(OP_LW, 4'd1, 4'd0, 4'd5, 1'b0));
    send(0, mk(OP_ADD, 4'd5, 4'd2, 4'd6, 1'b0));
    idle(1);
    phase = "load_r0_no_stall";
    send(0, mk(OP_LW, 4'd1, 4'd0, 4'd0, 1'b0));
    send(0, mk(OP_ADD, 4'd0, 4'd0, 4'd6, 1'b0));
    phase = "load_use_rt";
    send(0, mk(OP_LW, 4'd1, 4'd0, 4'd7, 1'b0));
    send(0, mk(OP_SW, 4'd2, 4'd7, 4'd0, 1'b0));
    phase = "load_then_jal";
    send(0, mk(OP_LW, 4'd1, 4'd0, 4'd7, 1'b0));
    send(0, mk(OP_JAL, 4'd7, 4'd7, 4'd1, 1'b0));
    idle(1);

    phase = "mul_hold3";
    send(0, mk(OP_MUL, 4'd1, 4'd2, 4'd4, 1'b0));
    send(0, mk(OP_ADD, 4'd4, 4'd2, 4'd3, 1'b0));
    idle(1);
    phase = "mul_nohold1";
    send(1, mk(OP_MUL, 4'd1, 4'd2, 4'd4, 1'b0));
    send(1, mk(OP_ADD, 4'd4, 4'd2, 4'd3, 1'b0));
    idle(1);

    phase = "flush_mul_jal";
    send(0, mk(OP_MUL, 4'd1, 4'd2, 4'd4, 1'b0));
    send(0, mk(OP_JAL, 4'd0, 4'd0, 4'd1, 1'b1));
    idle(2);

    phase = "illegal";
    send(0, mk(OP_BAD, 4'd1, 4'd2, 4'd3, 1'b0));
    idle(1);

    phase = "reset_mid_mul";
    send(0, mk(OP_MUL, 4'd1, 4'd2, 4'd4, 1'b0));
    idle(1);
    rst_req = 1'b1;
    idle(1);
    rst_req = 1'b0;
    idle(2);

    phase = "random";
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!have[k]) begin
          pend[k] = rand_stim();
          have[k] = 1'b1;
        end
        cur[k]       = pend[k];
        cur[k].flush = ($urandom_range(15) == 0);
      end
      rst_req = ($urandom_range(299) == 0);
      apply();
      rst_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (rdy[k]) have[k] = 1'b0;
      end
    end

    phase = "drain";
    idle(3);
    @(negedge clk);
    #1;
    vectors++;
    if (q[0].size() != 0 || q[1].size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expectations left unchecked, want 0/0", q[0].size(), q[1].size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
